// File: rtl/debug_dump_ctrl_pkg.sv
// rtl/debug_dump_ctrl_pkg.sv - shared state encoding and frame-order constants for the debug dump controller
//
// Purpose: FSM state and word-kind enums plus the frame layout constants
//          (34 header+register words, 4 bytes per word) used by the RTL and bench.
// Ports:   none (package).

package debug_dump_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD_PC  = 4'd1,
        ST_LOAD_CYC = 4'd2,
        ST_REQ_REG  = 4'd3,
        ST_CAP_REG  = 4'd4,
        ST_REQ_MEM  = 4'd5,
        ST_CAP_MEM  = 4'd6,
        ST_SEND     = 4'd7,
        ST_WAIT_TX  = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    // Which frame section the word currently in the shift register came from;
    // decides where the FSM goes once its last byte has been sent.
    typedef enum logic [1:0] {
        W_PC  = 2'd0,
        W_CYC = 2'd1,
        W_REG = 2'd2,
        W_MEM = 2'd3
    } word_t;

    localparam int N_REGS         = 32;
    localparam int N_HDR_WORDS    = 34;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/debug_dump_ctrl.sv
// rtl/debug_dump_ctrl.sv - streams PC, cycle count, register file and data memory as a UART byte frame
//
// Purpose: on i_start, sends i_pc, i_cycles, registers 0..31 and memory words
//          0..N_MEM_WORDS-1, each as 4 bytes LSB first, one byte per UART handshake.
// Ports:
//   i_clock, i_reset (async active-low)      clock / reset
//   i_start, i_abort                          begin / cancel a dump
//   i_pc, i_cycles                            header word sources
//   o_reg_addr, o_rd_reg, i_reg_data          register file read port (1-cycle latency)
//   o_mem_addr, o_rd_mem, i_mem_data          data memory read port (1-cycle latency)
//   o_tx_data, o_tx_start, i_tx_done          UART transmitter handshake
//   o_busy, o_done                            status

module debug_dump_ctrl
    import debug_dump_ctrl_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int NB_MEM_ADDR = 7,
    parameter int N_MEM_WORDS = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_cycles,
    input  logic [NB_DATA-1:0]     i_reg_data,
    input  logic [NB_DATA-1:0]     i_mem_data,
    input  logic                   i_tx_done,
    output logic [NB_REG-1:0]      o_reg_addr,
    output logic                   o_rd_reg,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    output logic                   o_rd_mem,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [1:0]             LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [NB_REG-1:0]      LAST_REG  = NB_REG'(N_REGS - 1);
    localparam logic [NB_MEM_ADDR-1:0] LAST_MEM  = NB_MEM_ADDR'(N_MEM_WORDS - 1);

    state_t                 state, nxt_state;
    word_t                  word, nxt_word;
    logic [NB_DATA-1:0]     shift, nxt_shift;
    logic [1:0]             byte_cnt, nxt_byte_cnt;
    logic [NB_REG-1:0]      reg_idx, nxt_reg_idx;
    logic [NB_MEM_ADDR-1:0] mem_idx, nxt_mem_idx;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            word     <= W_PC;
            shift    <= '0;
            byte_cnt <= '0;
            reg_idx  <= '0;
            mem_idx  <= '0;
        end else begin
            state    <= nxt_state;
            word     <= nxt_word;
            shift    <= nxt_shift;
            byte_cnt <= nxt_byte_cnt;
            reg_idx  <= nxt_reg_idx;
            mem_idx  <= nxt_mem_idx;
        end
    end

    always_comb begin
        nxt_state    = state;
        nxt_word     = word;
        nxt_shift    = shift;
        nxt_byte_cnt = byte_cnt;
        nxt_reg_idx  = reg_idx;
        nxt_mem_idx  = mem_idx;

        if (state != ST_IDLE && i_abort) begin
            // Abort wins over everything else, including a same-cycle i_tx_done.
            nxt_state    = ST_IDLE;
            nxt_word     = W_PC;
            nxt_shift    = '0;
            nxt_byte_cnt = '0;
            nxt_reg_idx  = '0;
            nxt_mem_idx  = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        nxt_state    = ST_LOAD_PC;
                        nxt_byte_cnt = '0;
                        nxt_reg_idx  = '0;
                        nxt_mem_idx  = '0;
                    end
                end
                ST_LOAD_PC: begin
                    nxt_shift = i_pc;
                    nxt_word  = W_PC;
                    nxt_state = ST_SEND;
                end
                ST_LOAD_CYC: begin
                    nxt_shift = i_cycles;
                    nxt_word  = W_CYC;
                    nxt_state = ST_SEND;
                end
                ST_REQ_REG: nxt_state = ST_CAP_REG;
                ST_CAP_REG: begin
                    nxt_shift = i_reg_data;
                    nxt_word  = W_REG;
                    nxt_state = ST_SEND;
                end
                ST_REQ_MEM: nxt_state = ST_CAP_MEM;
                ST_CAP_MEM: begin
                    nxt_shift = i_mem_data;
                    nxt_word  = W_MEM;
                    nxt_state = ST_SEND;
                end
                ST_SEND: nxt_state = ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        nxt_shift    = shift >> 8;
                        nxt_byte_cnt = byte_cnt + 2'd1;
                        if (byte_cnt != LAST_BYTE) begin
                            nxt_state = ST_SEND;
                        end else begin
                            unique case (word)
                                W_PC:  nxt_state = ST_LOAD_CYC;
                                W_CYC: nxt_state = ST_REQ_REG;
                                W_REG: begin
                                    // Index wraps 31 -> 0 and is not used again this frame.
                                    nxt_reg_idx = reg_idx + 1'b1;
                                    nxt_state   = (reg_idx == LAST_REG) ? ST_REQ_MEM : ST_REQ_REG;
                                end
                                W_MEM: begin
                                    if (mem_idx == LAST_MEM) begin
                                        nxt_mem_idx = '0;
                                        nxt_state   = ST_DONE;
                                    end else begin
                                        nxt_mem_idx = mem_idx + 1'b1;
                                        nxt_state   = ST_REQ_MEM;
                                    end
                                end
                                default: nxt_state = ST_IDLE;
                            endcase
                        end
                    end
                end
                ST_DONE: nxt_state = ST_IDLE;
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    // Shift register only moves on the i_tx_done that ends WAIT_TX, so the
    // byte presented in SEND stays put for the whole handshake.
    assign o_tx_data  = shift[7:0];
    assign o_reg_addr = reg_idx;
    assign o_mem_addr = mem_idx;
    assign o_rd_reg   = (state == ST_REQ_REG);
    assign o_rd_mem   = (state == ST_REQ_MEM);
    assign o_tx_start = (state == ST_SEND) && !i_abort;
    assign o_done     = (state == ST_DONE) && !i_abort;
    assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// tb/tb_debug_dump_ctrl.sv - self-checking bench for debug_dump_ctrl with a frame-level reference model

module tb_debug_dump_ctrl;
    import debug_dump_ctrl_pkg::*;

    localparam int N_MEM = 2;
    localparam int FRAME = BYTES_PER_WORD * (N_HDR_WORDS + N_MEM);
    localparam int BUDGET = 4000;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_cycles = '0;
    logic [31:0] i_reg_data = '0;
    logic [31:0] i_mem_data = '0;
    logic        i_tx_done = 1'b0;
    logic [4:0]  o_reg_addr;
    logic        o_rd_reg;
    logic [6:0]  o_mem_addr;
    logic        o_rd_mem;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;

    debug_dump_ctrl #(
        .NB_DATA(32), .NB_REG(5), .NB_MEM_ADDR(7), .N_MEM_WORDS(N_MEM)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_pc(i_pc), .i_cycles(i_cycles), .i_reg_data(i_reg_data), .i_mem_data(i_mem_data),
        .i_tx_done(i_tx_done), .o_reg_addr(o_reg_addr), .o_rd_reg(o_rd_reg),
        .o_mem_addr(o_mem_addr), .o_rd_mem(o_rd_mem), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0;
    int failures = 0;

    // Memory images seen by the DUT and the bytes the UART receives.
    logic [31:0] regs [32];
    logic [31:0] mem  [N_MEM];
    logic [7:0]  got [$];
    logic [7:0]  exp_bytes [$];
    logic [4:0]  raddr_log [$];
    logic [6:0]  maddr_log [$];

    // Responder state.
    int          done_cnt, rd_wide, tx_unstable, tx_overlap, cyc_cnt, abort_cyc;
    bit          prev_rd_reg, prev_rd_mem, waiting;
    logic [4:0]  prev_raddr;
    logic [6:0]  prev_maddr;
    int          wait_cnt, dly_min, dly_max, abort_at;
    logic [7:0]  held;
    bit          early_done_en, inject_start_en;

    // Frame model: words in transmit order, each split into 4 bytes LSB first.
    function automatic void build_expected();
        logic [31:0] words [$];
        exp_bytes.delete();
        words.push_back(i_pc);
        words.push_back(i_cycles);
        for (int k = 0; k < 32; k++) words.push_back(regs[k]);
        for (int m = 0; m < N_MEM; m++) words.push_back(mem[m]);
        foreach (words[w])
            for (int b = 0; b < 4; b++) exp_bytes.push_back(words[w][8*b +: 8]);
    endfunction

    function automatic int count_mismatch();
        int n = 0;
        if (got.size() != exp_bytes.size()) n++;
        for (int i = 0; i < exp_bytes.size(); i++)
            if (i >= got.size() || got[i] !== exp_bytes[i]) n++;
        return n;
    endfunction

    function automatic void clear_logs();
        got.delete(); raddr_log.delete(); maddr_log.delete();
        done_cnt = 0; rd_wide = 0; tx_unstable = 0; tx_overlap = 0;
        prev_rd_reg = 0; prev_rd_mem = 0; waiting = 0; wait_cnt = 0;
        early_done_en = 0; inject_start_en = 0; abort_at = -1; abort_cyc = -1;
        dly_min = 3; dly_max = 3;
    endfunction

    function automatic void randomize_images();
        for (int k = 0; k < 32; k++) regs[k] = $urandom();
        for (int m = 0; m < N_MEM; m++) mem[m] = $urandom();
        i_pc = $urandom();
        i_cycles = $urandom();
    endfunction

    // One clock: inputs change only at the falling edge, then the UART/memory
    // responder looks at the outputs and schedules inputs for the next edge.
    task automatic cycle();
        @(posedge i_clock);
        @(negedge i_clock);
        cyc_cnt++;
        i_start = 0; i_abort = 0; i_tx_done = 0;
        if (o_rd_reg) begin
            if (prev_rd_reg) rd_wide++;
            raddr_log.push_back(o_reg_addr);
        end
        if (o_rd_mem) begin
            if (prev_rd_mem) rd_wide++;
            maddr_log.push_back(o_mem_addr);
        end
        // Read data is valid only in the cycle after the strobe; junk otherwise.
        i_reg_data = prev_rd_reg ? regs[prev_raddr] : $urandom();
        i_mem_data = prev_rd_mem ? mem[prev_maddr % N_MEM] : $urandom();
        if (inject_start_en && prev_rd_mem) i_start = 1;
        prev_rd_reg = o_rd_reg; prev_raddr = o_reg_addr;
        prev_rd_mem = o_rd_mem; prev_maddr = o_mem_addr;
        if (waiting) begin
            if (o_tx_data !== held) tx_unstable++;
            if (o_tx_start) tx_overlap++;
            wait_cnt--;
            if (inject_start_en && wait_cnt == 1) i_start = 1;
            if (wait_cnt <= 0) begin
                i_tx_done = 1;
                if (got.size() - 1 == abort_at) begin
                    i_abort = 1;
                    abort_cyc = cyc_cnt;
                end
                waiting = 0;
            end
        end else if (o_tx_start) begin
            got.push_back(o_tx_data);
            held = o_tx_data;
            waiting = 1;
            wait_cnt = $urandom_range(dly_max, dly_min);
            if (early_done_en) i_tx_done = 1;
        end
        if (o_done) done_cnt++;
    endtask

    // Pulse i_start and clock until o_busy drops or the budget runs out.
    task automatic run_frame(output bit timed_out);
        int n = 0;
        i_start = 1;
        cycle();
        while (o_busy && n < BUDGET) begin
            cycle();
            n++;
        end
        timed_out = (n >= BUDGET);
    endtask

    task automatic test_reset();
        i_reset = 0;
        #2;
        checks++;
        if ({o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_rd_reg, o_rd_mem, o_busy, o_done} !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0",
                {o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_rd_reg, o_rd_mem, o_busy, o_done});
        end
        clear_logs();
        cycle(); cycle();
        i_reset = 1;
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (o_busy !== 1'b0 || got.size() != 0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b bytes=%0d required busy=0 bytes=0", o_busy, got.size());
        end
    endtask

    task automatic test_basic_frame();
        bit to;
        clear_logs();
        i_pc = 32'h0000_0010; i_cycles = 32'h0000_0105;
        for (int k = 0; k < 32; k++) regs[k] = k;
        mem[0] = 32'hDEAD_BEEF; mem[1] = 32'h1234_5678;
        build_expected();
        run_frame(to);
        checks++;
        if (to) begin failures++; $display("FAIL basic_timeout: frame did not end"); end
        checks++;
        if (got.size() != FRAME) begin
            failures++; $display("FAIL basic_len: got %0d bytes required %0d", got.size(), FRAME);
        end
        checks++;
        if (got.size() < 8 || {got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]} !== 64'h10000000_05010000) begin
            failures++; $display("FAIL basic_head: first bytes wrong, %0d received", got.size());
        end
        checks++;
        if (got.size() < 8 || {got[got.size()-8], got[got.size()-7], got[got.size()-6], got[got.size()-5],
                               got[got.size()-4], got[got.size()-3], got[got.size()-2], got[got.size()-1]}
                              !== 64'hEFBEADDE_78563412) begin
            failures++; $display("FAIL basic_tail: last bytes wrong, %0d received", got.size());
        end
        checks++;
        if (count_mismatch() != 0) begin
            failures++; $display("FAIL basic_bytes: %0d mismatching bytes required 0", count_mismatch());
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt); end
        checks++;
        if (tx_unstable != 0 || tx_overlap != 0) begin
            failures++; $display("FAIL basic_txhold: unstable=%0d overlap=%0d required 0/0", tx_unstable, tx_overlap);
        end
    endtask

    task automatic test_read_timing();
        bit to;
        int bad_addr;
        for (int rep = 0; rep < 2; rep++) begin
            clear_logs();
            randomize_images();
            dly_min = 1; dly_max = 4;
            build_expected();
            run_frame(to);
            checks++;
            if (to || count_mismatch() != 0) begin
                failures++; $display("FAIL timing_bytes: rep %0d timeout=%0b mismatches=%0d required 0", rep, to, count_mismatch());
            end
            checks++;
            if (rd_wide != 0) begin failures++; $display("FAIL timing_strobe_width: %0d wide strobes required 0", rd_wide); end
            bad_addr = (raddr_log.size() == 32) ? 0 : 1;
            foreach (raddr_log[i]) if (raddr_log[i] != 5'(i)) bad_addr++;
            checks++;
            if (bad_addr != 0) begin
                failures++; $display("FAIL timing_reg_addr: %0d strobes, %0d out of order, required 32 in order", raddr_log.size(), bad_addr);
            end
            checks++;
            if (maddr_log.size() != N_MEM || maddr_log[0] != 7'd0 || maddr_log[N_MEM-1] != 7'(N_MEM-1)) begin
                failures++; $display("FAIL timing_mem_addr: %0d strobes required %0d in order", maddr_log.size(), N_MEM);
            end
            checks++;
            if (done_cnt != 1) begin failures++; $display("FAIL timing_done: got %0d required 1", done_cnt); end
        end
    endtask

    task automatic test_abort();
        bit to;
        clear_logs();
        randomize_images();
        abort_at = 50;
        dly_min = 1; dly_max = 3;
        run_frame(to);
        checks++;
        if (to || o_busy !== 1'b0 || cyc_cnt != abort_cyc + 1) begin
            failures++; $display("FAIL abort_idle: busy=%b idle %0d cycles after abort required 1", o_busy, cyc_cnt - abort_cyc);
        end
        checks++;
        if (got.size() != 51 || done_cnt != 0) begin
            failures++; $display("FAIL abort_stop: bytes=%0d done=%0d required 51/0", got.size(), done_cnt);
        end
        for (int i = 0; i < 10; i++) cycle();
        checks++;
        if (got.size() != 51 || o_busy !== 1'b0) begin
            failures++; $display("FAIL abort_quiet: bytes=%0d busy=%b required 51/0", got.size(), o_busy);
        end
        clear_logs();
        i_pc = 32'h0000_0010;
        build_expected();
        run_frame(to);
        checks++;
        if (got.size() == 0 || got[0] !== 8'h10) begin
            failures++; $display("FAIL abort_restart_first: got %h required 10", got.size() ? got[0] : 8'hxx);
        end
        checks++;
        if (to || count_mismatch() != 0 || done_cnt != 1) begin
            failures++; $display("FAIL abort_restart_frame: mismatches=%0d done=%0d required 0/1", count_mismatch(), done_cnt);
        end
    endtask

    task automatic test_ignored_start();
        bit to;
        clear_logs();
        randomize_images();
        inject_start_en = 1;
        build_expected();
        run_frame(to);
        checks++;
        if (to || got.size() != FRAME || count_mismatch() != 0) begin
            failures++; $display("FAIL ignored_start: bytes=%0d mismatches=%0d required %0d/0", got.size(), count_mismatch(), FRAME);
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL ignored_start_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int n = 0;
        clear_logs();
        randomize_images();
        i_start = 1;
        cycle();
        while (!(o_rd_reg && o_reg_addr == 5'd7) && n < BUDGET) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= BUDGET) begin failures++; $display("FAIL midreset_reach: register 7 read never seen"); end
        i_reset = 0;
        #1;
        checks++;
        if ({o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_rd_reg, o_rd_mem, o_busy, o_done} !== 25'd0) begin
            failures++; $display("FAIL midreset_async: got %h required 0",
                {o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_rd_reg, o_rd_mem, o_busy, o_done});
        end
        cycle(); cycle();
        i_reset = 1;
        clear_logs();
        for (int i = 0; i < 20; i++) cycle();
        checks++;
        if (got.size() != 0 || raddr_log.size() != 0 || o_busy !== 1'b0 || done_cnt != 0) begin
            failures++; $display("FAIL midreset_quiet: bytes=%0d reads=%0d busy=%b done=%0d required 0", got.size(), raddr_log.size(), o_busy, done_cnt);
        end
        build_expected();
        run_frame(to);
        checks++;
        if (to || count_mismatch() != 0 || done_cnt != 1) begin
            failures++; $display("FAIL midreset_restart: mismatches=%0d done=%0d required 0/1", count_mismatch(), done_cnt);
        end
    endtask

    task automatic test_early_done();
        bit to;
        clear_logs();
        randomize_images();
        for (int i = 0; i < 4; i++) begin
            i_tx_done = 1;
            i_abort = (i % 2 == 0);
            cycle();
        end
        checks++;
        if (o_busy !== 1'b0 || got.size() != 0 || done_cnt != 0) begin
            failures++; $display("FAIL early_idle: busy=%b bytes=%0d required 0/0", o_busy, got.size());
        end
        early_done_en = 1;
        dly_min = 2; dly_max = 4;
        build_expected();
        run_frame(to);
        checks++;
        if (to || got.size() != FRAME || count_mismatch() != 0 || done_cnt != 1) begin
            failures++; $display("FAIL early_send: bytes=%0d mismatches=%0d done=%0d required %0d/0/1", got.size(), count_mismatch(), done_cnt, FRAME);
        end
    endtask

    initial begin
        cyc_cnt = 0;
        clear_logs();
        test_reset();
        test_basic_frame();
        test_read_timing();
        test_abort();
        test_ignored_start();
        test_reset_mid_frame();
        test_early_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
